readout_sequencer: RTL and testbench

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/sensor_pkg.sv | 26 ++
 rtl/readout_sequencer_cycle_timer.sv | 36 +++
 rtl/readout_sequencer.sv | 176 +++++++++++++++++
 tb/tb_readout_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared state encoding and default timing constants for the pixel-array readout sequencer.
// Latency: n/a. Backpressure: n/a.
package sensor_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_ERASE   = 3'd1,
        SEQ_EXPOSE  = 3'd2,
        SEQ_CONVERT = 3'd3,
        SEQ_RELEASE = 3'd4,
        SEQ_DONE    = 3'd5
    } seq_state_t;

    localparam int DEF_ROWS           = 3;
    localparam int DEF_WIDTH          = 2;
    localparam int DEF_ERASE_CYCLES   = 4;
    localparam int DEF_EXPOSE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/readout_sequencer_cycle_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement, holds at zero.
// Latency: zero reflects the registered count. Backpressure: none.
module cycle_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Frame sequencer for a pixel array: erase, expose, then convert each row with a per-state timeout.
// Latency: all outputs registered, one cycle after the state decision. Backpressure: none; start is ignored while busy.
module readout_sequencer
    import sensor_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int ERASE_CYCLES   = DEF_ERASE_CYCLES,
    parameter int EXPOSE_CYCLES  = DEF_EXPOSE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           row_done,
    output logic           erase,
    output logic           expose,
    output logic           enable,
    output logic [WIDTH:0] decoder_select,
    output logic           busy,
    output logic           frame_done,
    output logic           timeout_err
);

    localparam logic [2:0] ST_IDLE    = SEQ_IDLE;
    localparam logic [2:0] ST_ERASE   = SEQ_ERASE;
    localparam logic [2:0] ST_EXPOSE  = SEQ_EXPOSE;
    localparam logic [2:0] ST_CONVERT = SEQ_CONVERT;
    localparam logic [2:0] ST_RELEASE = SEQ_RELEASE;
    localparam logic [2:0] ST_DONE    = SEQ_DONE;

    // Timer reloads with N-1 so a state holding until zero lasts exactly N cycles.
    localparam int            MAXC      = max_of3(ERASE_CYCLES, EXPOSE_CYCLES, TIMEOUT_CYCLES);
    localparam int            TW        = $clog2(MAXC);
    localparam logic [TW-1:0] ERASE_LD  = TW'(ERASE_CYCLES - 1);
    localparam logic [TW-1:0] EXPOSE_LD = TW'(EXPOSE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LD    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH:0] ROW_LAST = (WIDTH+1)'(ROWS - 1);

    logic [2:0]     state_q, state_d;
    logic [WIDTH:0] row_q, row_d;
    logic           erase_q, erase_d;
    logic           expose_q, expose_d;
    logic           enable_q, enable_d;
    logic           busy_q, busy_d;
    logic           frame_done_q, frame_done_d;
    logic           timeout_err_q, timeout_err_d;

    logic           tmr_load;
    logic           tmr_dec;
    logic [TW-1:0]  tmr_val;
    logic           tmr_zero;

    cycle_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        timeout_err_d = timeout_err_q;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        tmr_val       = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_ERASE;
                    row_d         = '0;
                    timeout_err_d = 1'b0;
                    tmr_load      = 1'b1;
                    tmr_val       = ERASE_LD;
                end
            end
            ST_ERASE: begin
                if (tmr_zero) begin
                    state_d  = ST_EXPOSE;
                    tmr_load = 1'b1;
                    tmr_val  = EXPOSE_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_EXPOSE: begin
                if (tmr_zero) begin
                    state_d  = ST_CONVERT;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_CONVERT: begin
                // A row_done arriving on the final allowed cycle still counts as success.
                if (row_done) begin
                    state_d  = ST_RELEASE;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LD;
                end else if (tmr_zero) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!row_done) begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_CONVERT;
                        row_d    = row_q + (WIDTH+1)'(1);
                        tmr_load = 1'b1;
                        tmr_val  = TMO_LD;
                    end
                end else if (tmr_zero) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        erase_d      = (state_d == ST_ERASE);
        expose_d     = (state_d == ST_EXPOSE);
        enable_d     = (state_d == ST_CONVERT);
        frame_done_d = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            erase_q       <= 1'b0;
            expose_q      <= 1'b0;
            enable_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            erase_q       <= erase_d;
            expose_q      <= expose_d;
            enable_q      <= enable_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign erase          = erase_q;
    assign expose         = expose_q;
    assign enable         = enable_q;
    assign decoder_select = row_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with a row_done pixel-array model and a row/frame scoreboard.
module tb_readout_sequencer;

    localparam int ROWS     = 3;
    localparam int WIDTH    = 2;
    localparam int ERASE_N  = 4;
    localparam int EXPOSE_N = 16;
    localparam int TMO_N    = 20;
    localparam int RD_DELAY = 10;
    localparam int BUDGET   = 400;

    logic           clk;
    logic           reset;
    logic           start;
    logic           row_done;
    logic           erase;
    logic           expose;
    logic           enable;
    logic [WIDTH:0] decoder_select;
    logic           busy;
    logic           frame_done;
    logic           timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    int exp_rows[$];
    int exp_final[$];

    logic stuck    = 1'b0;
    int   rel_hold = 0;

    readout_sequencer #(
        .ROWS           (ROWS),
        .WIDTH          (WIDTH),
        .ERASE_CYCLES   (ERASE_N),
        .EXPOSE_CYCLES  (EXPOSE_N),
        .TIMEOUT_CYCLES (TMO_N)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .row_done       (row_done),
        .erase          (erase),
        .expose         (expose),
        .enable         (enable),
        .decoder_select (decoder_select),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input int nrows, input bit with_done);
        for (int r = 0; r < nrows; r++) exp_rows.push_back(r);
        if (with_done) exp_final.push_back(ROWS - 1);
    endtask

    // Pixel-array model: row_done rises RD_DELAY cycles into enable, falls rel_hold cycles after enable drops.
    int en_cnt  = 0;
    int rel_cnt = 0;
    initial row_done = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset || stuck) begin
            en_cnt   = 0;
            rel_cnt  = 0;
            row_done = 1'b0;
        end else if (enable) begin
            en_cnt++;
            rel_cnt = 0;
            if (en_cnt >= RD_DELAY) row_done = 1'b1;
        end else begin
            en_cnt = 0;
            if (row_done) begin
                if (rel_cnt >= rel_hold) row_done = 1'b0;
                else rel_cnt++;
            end
        end
    end

    // Monitor: phase lengths, exclusivity, decoder_select stability and the scoreboard pops.
    int             ers_run = 0;
    int             exp_run = 0;
    logic           prev_en = 1'b0;
    logic           prev_er = 1'b0;
    logic           prev_fd = 1'b0;
    logic [WIDTH:0] prev_sel = '0;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("erase_expose_excl", {31'd0, erase & expose}, 32'd0);
            if (erase) ers_run++;
            else if (ers_run != 0) begin
                chk("erase_len", ers_run, ERASE_N);
                ers_run = 0;
            end
            if (expose) exp_run++;
            else if (exp_run != 0) begin
                chk("expose_len", exp_run, EXPOSE_N);
                exp_run = 0;
            end
            if (!((enable && !prev_en) || (erase && !prev_er)))
                chk("sel_stable", decoder_select, prev_sel);
            if (enable && !prev_en) begin
                vectors++;
                assert (exp_rows.size() > 0) else begin
                    miscompares++;
                    $error("FAIL unexp_row: observed row %0d, expected no conversion", decoder_select);
                end
                if (exp_rows.size() > 0) chk("row_sel", decoder_select, exp_rows.pop_front());
            end
            if (frame_done) begin
                chk("frame_done_width", {31'd0, prev_fd}, 32'd0);
                vectors++;
                assert (exp_final.size() > 0) else begin
                    miscompares++;
                    $error("FAIL unexp_frame_done: observed frame_done=1, expected none");
                end
                if (exp_final.size() > 0) chk("final_row", decoder_select, exp_final.pop_front());
            end
        end else begin
            ers_run = 0;
            exp_run = 0;
        end
        prev_en  = enable;
        prev_er  = erase;
        prev_fd  = frame_done;
        prev_sel = decoder_select;
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        step(3);
        chk("rst_erase", erase, 0);
        chk("rst_expose", expose, 0);
        chk("rst_enable", enable, 0);
        chk("rst_sel", decoder_select, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout", timeout_err, 0);

        // Normal frame, started the cycle reset falls.
        push_frame(ROWS, 1'b1);
        reset = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("first_erase", erase, 1);
        chk("first_busy", busy, 1);
        n = 0;
        while (!frame_done && n < BUDGET) begin step(1); n++; end
        chk("f1_done", frame_done, 1);
        step(1);
        chk("f1_idle_busy", busy, 0);
        chk("f1_pulse_end", frame_done, 0);

        // Start pulse during EXPOSE is ignored.
        push_frame(ROWS, 1'b1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (!expose && n < BUDGET) begin step(1); n++; end
        chk("busy_start_in_expose", expose, 1);
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("busy_start_still_expose", expose, 1);
        n = 0;
        while (!frame_done && n < BUDGET) begin step(1); n++; end
        chk("f2_done", frame_done, 1);
        step(2);
        chk("f2_no_restart", busy, 0);

        // Slow release: row_done lingers after enable falls.
        rel_hold = 5;
        push_frame(ROWS, 1'b1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (!enable && n < BUDGET) begin step(1); n++; end
        while (enable && n < BUDGET) begin step(1); n++; end
        chk("slow_rel_enable_low", enable, 0);
        n = 0;
        while (decoder_select == 0 && n < BUDGET) begin step(1); n++; end
        chk("slow_rel_hold_cycles", n, rel_hold + 1);
        chk("slow_rel_next_row", decoder_select, 1);
        n = 0;
        while (!frame_done && n < BUDGET) begin step(1); n++; end
        chk("f3_done", frame_done, 1);
        rel_hold = 0;
        step(2);

        // Stuck row_done: timeout after TMO_N convert cycles, no frame_done.
        stuck = 1'b1;
        push_frame(1, 1'b0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (!enable && n < BUDGET) begin step(1); n++; end
        n = 0;
        while (enable && n < BUDGET) begin step(1); n++; end
        chk("tmo_convert_len", n, TMO_N);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_enable", enable, 0);
        chk("tmo_busy", busy, 0);
        chk("tmo_no_frame_done", frame_done, 0);
        step(3);
        chk("tmo_sticky", timeout_err, 1);
        stuck = 1'b0;

        // Reset during CONVERT of row 1, then a fresh frame from row 0.
        push_frame(2, 1'b0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_clears_tmo", timeout_err, 0);
        n = 0;
        while (!(enable && decoder_select == 1) && n < BUDGET) begin step(1); n++; end
        chk("mid_row1_enable", enable, 1);
        step(3);
        reset = 1'b1;
        step(1);
        chk("mid_rst_erase", erase, 0);
        chk("mid_rst_expose", expose, 0);
        chk("mid_rst_enable", enable, 0);
        chk("mid_rst_sel", decoder_select, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        reset = 1'b0;
        push_frame(ROWS, 1'b1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("restart_erase", erase, 1);
        n = 0;
        while (!frame_done && n < BUDGET) begin step(1); n++; end
        chk("f4_done", frame_done, 1);
        step(2);

        // Continuous start: two back-to-back frames with one IDLE cycle between.
        push_frame(ROWS, 1'b1);
        push_frame(ROWS, 1'b1);
        start = 1'b1;
        n = 0;
        while (!frame_done && n < BUDGET) begin step(1); n++; end
        chk("cont_f1_done", frame_done, 1);
        step(1);
        chk("cont_gap_busy", busy, 0);
        chk("cont_gap_erase", erase, 0);
        step(1);
        chk("cont_f2_erase", erase, 1);
        chk("cont_f2_busy", busy, 1);
        start = 1'b0;
        n = 0;
        while (!frame_done && n < BUDGET) begin step(1); n++; end
        chk("cont_f2_done", frame_done, 1);
        step(3);
        chk("cont_end_idle", busy, 0);

        chk("rows_all_seen", exp_rows.size(), 0);
        chk("frames_all_seen", exp_final.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
